// File: rtl/i2c_pkg.sv
// i2c_pkg: command/state encodings and phase/bit counts shared by the I2C master.
package i2c_pkg;
   typedef enum logic [1:0] {CMD_START = 2'd0, CMD_WRITE = 2'd1, CMD_READ = 2'd2, CMD_STOP = 2'd3} cmd_t;
   typedef enum logic [2:0] {IDLE, START, BIT, STOP, ERR} state_t;
   localparam int PHASES = 4;
   localparam int BITS   = 9;
endpackage

// File: rtl/i2c_master.sv
// i2c_master: byte-level open-drain I2C master timed by edges of clk_gen_i.
// Ports: clk_i/rst clock and sync reset; clk_gen_i phase strobe (each edge is a tick);
// cmd_valid/cmd_ready/cmd/wr_data/rd_nack command handshake; rd_data/ack_o/done/err
// results; bus_active between START and STOP; scl_oe/sda_oe pull-low enables;
// scl_i/sda_i synchronised pad levels.
module i2c_master
   import i2c_pkg::*;
#(
   parameter bit STRETCH_EN = 1'b1
) (
   input  logic       clk_i,
   input  logic       rst,
   input  logic       clk_gen_i,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd,
   input  logic [7:0] wr_data,
   input  logic       rd_nack,
   output logic [7:0] rd_data,
   output logic       ack_o,
   output logic       done,
   output logic       err,
   output logic       bus_active,
   output logic       scl_oe,
   output logic       sda_oe,
   input  logic       scl_i,
   input  logic       sda_i
);
   state_t                      st;
   cmd_t                        c;
   logic [$clog2(PHASES)-1:0]   ph;
   logic [3:0]                  bn;
   logic [7:0]                  sh;
   logic                        nack, gen_q, tick, hold, adv, ack_bit;

   assign tick    = clk_gen_i ^ gen_q;
   // a slave holding SCL low after release stalls the sampling phase
   assign hold    = STRETCH_EN && ph == 2'd2 && !scl_i;
   assign adv     = tick && !hold;
   assign ack_bit = bn == 4'(BITS - 1);

   always_ff @(posedge clk_i) begin
      if (rst) begin
         st         <= IDLE;
         c          <= CMD_START;
         ph         <= '0;
         bn         <= '0;
         sh         <= '0;
         nack       <= 1'b0;
         gen_q      <= 1'b0;
         cmd_ready  <= 1'b1;
         done       <= 1'b0;
         err        <= 1'b0;
         ack_o      <= 1'b0;
         rd_data    <= '0;
         bus_active <= 1'b0;
         scl_oe     <= 1'b0;
         sda_oe     <= 1'b0;
      end else begin
         gen_q <= clk_gen_i;
         done  <= 1'b0;
         err   <= 1'b0;
         case (st)
            IDLE: begin
               if (done) cmd_ready <= 1'b1;
               else if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  c         <= cmd_t'(cmd);
                  sh        <= wr_data;
                  nack      <= rd_nack;
                  ph        <= '0;
                  bn        <= '0;
                  if (cmd == CMD_START) st <= START;
                  else if (!bus_active) st <= ERR;
                  else if (cmd == CMD_STOP) st <= STOP;
                  else st <= BIT;
               end
            end
            ERR: begin
               // one spare cycle so done/err land two cycles after acceptance
               if (ph == 2'd0) ph <= 2'd1;
               else begin
                  done <= 1'b1;
                  err  <= 1'b1;
                  st   <= IDLE;
               end
            end
            START: if (adv) begin
               ph <= ph + 2'd1;
               case (ph)
                  2'd0: sda_oe <= 1'b0;
                  2'd1: scl_oe <= 1'b0;
                  2'd2: sda_oe <= 1'b1;
                  default: begin
                     scl_oe     <= 1'b1;
                     done       <= 1'b1;
                     bus_active <= 1'b1;
                     st         <= IDLE;
                  end
               endcase
            end
            STOP: if (adv) begin
               ph <= ph + 2'd1;
               case (ph)
                  2'd0: sda_oe <= 1'b1;
                  2'd1: scl_oe <= 1'b0;
                  2'd2: sda_oe <= 1'b0;
                  default: begin
                     done       <= 1'b1;
                     bus_active <= 1'b0;
                     st         <= IDLE;
                  end
               endcase
            end
            BIT: if (adv) begin
               ph <= ph + 2'd1;
               case (ph)
                  2'd0: sda_oe <= ack_bit ? (c == CMD_READ && !nack) : (c == CMD_WRITE && !sh[7]);
                  2'd1: scl_oe <= 1'b0;
                  2'd2: begin
                     // data bits shift the line into sh; the ACK bit leaves sh holding the byte
                     if (!ack_bit) sh <= {sh[6:0], sda_i};
                     else if (c == CMD_WRITE) ack_o <= ~sda_i;
                  end
                  default: begin
                     scl_oe <= 1'b1;
                     bn     <= bn + 4'd1;
                     if (ack_bit) begin
                        done <= 1'b1;
                        st   <= IDLE;
                        if (c == CMD_READ) rd_data <= sh;
                     end
                  end
               endcase
            end
            default: st <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: scoreboard bench for i2c_master with an open-drain slave model.
`timescale 1ns/1ps
module tb_i2c_master;
   typedef struct {
      bit         e;
      int         tmin;
      int         tmax;
      logic       ack;
      logic [7:0] rd;
      logic       bus;
   } exp_t;

   logic clk_i = 0, rst = 1, clk_gen = 0;
   logic cmd_valid = 0, rd_nack = 0;
   logic [1:0] cmd = 0;
   logic [7:0] wr_data = 0;
   logic cmd_ready, ack_o, done, err, bus_active, scl_oe, sda_oe;
   logic [7:0] rd_data;
   logic scl, sda, sda_low, scl_hold = 0;

   int n_chk = 0, n_fail = 0;
   int ticks = 0, cyc = 0;
   logic g_last = 0;
   exp_t q[$];

   int mode = 0, cnt = -1, unstable = 0, rd9_bad = 0;
   bit stretch = 0;
   logic [7:0] wcap = 0, rd_byte = 8'h3C;
   logic scl_p = 1, sda_p = 1, sda_r = 1;
   event ev_stretch;
   time t_sda = 0, t_scl = 0;

   i2c_master #(.STRETCH_EN(1'b1)) dut (
      .clk_i(clk_i), .rst(rst), .clk_gen_i(clk_gen),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd), .wr_data(wr_data), .rd_nack(rd_nack),
      .rd_data(rd_data), .ack_o(ack_o), .done(done), .err(err), .bus_active(bus_active),
      .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_i(scl), .sda_i(sda)
   );

   assign scl = !(scl_oe || scl_hold);
   assign sda = !(sda_oe || sda_low);
   assign sda_low = (mode == 1 && cnt == 8) || (mode == 2 && cnt >= 0 && cnt < 8 && !rd_byte[7 - cnt]);

   always #50 clk_i = ~clk_i;

   // 200 kHz clk_gen model: an edge every 25 cycles of the 10 MHz clock
   initial begin
      int div;
      div = 0;
      forever begin
         @(posedge clk_i);
         #1;
         if (rst) begin clk_gen = 0; div = 0; end
         else if (++div == 25) begin div = 0; clk_gen = ~clk_gen; end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge sda_oe) t_sda = $time;
   always @(posedge scl_oe) t_scl = $time;

   initial forever begin
      @(ev_stretch);
      scl_hold = 1;
      #20000;
      scl_hold = 0;
   end

   // slave: frames bits on SCL falls, ACKs writes, transmits rd_byte on reads
   initial forever begin
      @(negedge clk_i);
      if (scl_p && scl && sda_p && !sda) cnt = -1;
      if (scl_p && !scl) begin
         if (mode == 1 && cnt >= 0 && cnt < 8) begin
            wcap = {wcap[6:0], sda_r};
            if (sda !== sda_r) unstable++;
         end
         if (mode == 1 && stretch && cnt == 2) -> ev_stretch;
         cnt = (cnt == 8) ? 0 : cnt + 1;
      end
      if (!scl_p && scl) sda_r = sda;
      if (mode == 2 && cnt == 8 && sda_oe) rd9_bad++;
      scl_p = scl;
      sda_p = sda;
   end

   // monitor: pops an expectation at every done and measures ticks/cycles since acceptance
   initial forever begin
      exp_t e;
      @(negedge clk_i);
      if (done) begin
         if (q.size() == 0) chk("unexpected_done", 1, 0);
         else begin
            e = q.pop_front();
            chk("err", err, e.e);
            if (e.e) begin
               chk("err_latency", cyc, 2);
               chk("err_lines", {scl_oe, sda_oe}, 0);
            end else begin
               n_chk++;
               if (ticks < e.tmin || ticks > e.tmax) begin
                  n_fail++;
                  $display("FAIL ticks: got %0d expected %0d..%0d", ticks, e.tmin, e.tmax);
               end
            end
            chk("ack_o", ack_o, e.ack);
            chk("rd_data", rd_data, e.rd);
            chk("bus_active", bus_active, e.bus);
            chk("ready_low_at_done", cmd_ready, 0);
         end
      end
      if (rst || (cmd_valid && cmd_ready)) begin ticks = 0; cyc = 0; end
      else begin
         cyc++;
         if (clk_gen != g_last) ticks++;
      end
      g_last = clk_gen;
   end

   task automatic send(input logic [1:0] c, input logic [7:0] d, input logic n, input exp_t e);
      int k;
      k = 0;
      while (!cmd_ready && k < 1000) begin @(posedge clk_i); #1; k++; end
      if (!cmd_ready) chk("ready_timeout", 0, 1);
      q.push_back(e);
      cmd = c; wr_data = d; rd_nack = n; cmd_valid = 1;
      @(posedge clk_i); #1;
      cmd_valid = 0;
   endtask

   task automatic wait_done(input int lim);
      int k;
      k = 0;
      while (!done && k < lim) begin @(posedge clk_i); #1; k++; end
      if (!done) chk("done_timeout", 0, 1);
      else begin @(posedge clk_i); #1; end
   endtask

   function automatic exp_t mk(bit e, int tmin, int tmax, logic ack, logic [7:0] rd, logic bus);
      exp_t x;
      x.e = e; x.tmin = tmin; x.tmax = tmax; x.ack = ack; x.rd = rd; x.bus = bus;
      return x;
   endfunction

   initial begin
      int k, dn;
      #5_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int k, dn;
      repeat (4) @(posedge clk_i);
      #1 rst = 0;
      @(posedge clk_i); #1;
      chk("rst_scl_oe", scl_oe, 0);
      chk("rst_sda_oe", sda_oe, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_done_err", {done, err}, 0);
      chk("rst_ack_rd", {ack_o, rd_data}, 0);
      chk("rst_bus_active", bus_active, 0);

      send(2'd3, 8'h00, 0, mk(1, 0, 0, 0, 8'h00, 0));
      wait_done(50);
      send(2'd2, 8'h00, 0, mk(1, 0, 0, 0, 8'h00, 0));
      wait_done(50);

      send(2'd0, 8'h00, 0, mk(0, 4, 4, 0, 8'h00, 1));
      wait_done(500);
      chk("start_sda_before_scl_ns", 32'(t_scl - t_sda), 2500);

      mode = 1; unstable = 0;
      send(2'd1, 8'hA5, 0, mk(0, 36, 36, 1, 8'h00, 1));
      wait_done(2000);
      chk("write_bits", wcap, 8'hA5);
      chk("write_sda_stable", unstable, 0);

      mode = 2; rd9_bad = 0;
      send(2'd2, 8'h00, 1, mk(0, 36, 36, 1, 8'h3C, 1));
      wait_done(2000);
      mode = 0;
      chk("read_nack_sda_released", rd9_bad, 0);

      mode = 1; stretch = 1; unstable = 0;
      send(2'd1, 8'h5A, 0, mk(0, 41, 43, 1, 8'h3C, 1));
      wait_done(2000);
      stretch = 0;
      chk("stretch_write_bits", wcap, 8'h5A);
      chk("stretch_sda_stable", unstable, 0);
      mode = 0;

      send(2'd3, 8'h00, 0, mk(0, 4, 4, 1, 8'h3C, 0));
      wait_done(500);
      chk("stop_lines_released", {scl_oe, sda_oe}, 0);

      send(2'd0, 8'h00, 0, mk(0, 4, 4, 1, 8'h3C, 1));
      wait_done(500);
      mode = 1;
      send(2'd1, 8'hFF, 0, mk(0, 36, 36, 1, 8'h3C, 1));
      k = 0;
      while (ticks < 17 && k < 2000) begin @(negedge clk_i); k++; end
      if (ticks < 17) chk("tick17_timeout", 0, 1);
      rst = 1;
      @(posedge clk_i); #1;
      q.delete();
      chk("midrst_lines", {scl_oe, sda_oe}, 0);
      chk("midrst_cmd_ready", cmd_ready, 1);
      chk("midrst_bus_active", bus_active, 0);
      rst = 0;
      mode = 0;
      dn = 0;
      repeat (1200) begin @(posedge clk_i); #1; if (done) dn++; end
      chk("midrst_no_done", dn, 0);

      send(2'd0, 8'h00, 0, mk(0, 4, 4, 0, 8'h00, 1));
      wait_done(500);

      repeat (5) @(posedge clk_i);
      chk("queue_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
